// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared state encoding and defaults for the SD engine arbiter
// Purpose: FSM state type and default parameter values used by sd_arbiter.
// Ports: none (package).
package sd_pkg;

  typedef enum logic [2:0] {
    ST_RECOVER = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_DONE    = 3'd4
  } sd_state_t;

  // 200 ms at the 100 MHz bus clock.
  localparam int unsigned SD_TIMEOUT_DEFAULT    = 32'd20000000;
  localparam int unsigned SD_RES_CYCLES_DEFAULT = 32'd4;

endpackage

// File: rtl/sd_rr_pick.sv
// rtl/sd_rr_pick.sv - combinational 2-way round-robin picker
// Purpose: choose one of two requesters, favouring the one not served last.
// Ports:
//   i_req0, i_req1  request levels
//   i_last          port that was served most recently
//   o_valid         at least one request present
//   o_sel           winning port (meaningful only when o_valid)
module sd_rr_pick (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_valid,
  output logic o_sel
);

  assign o_valid = i_req0 | i_req1;
  // On a tie the port other than the last winner goes; otherwise the lone requester.
  assign o_sel   = (i_req0 & i_req1) ? ~i_last : i_req1;

endmodule

// File: rtl/sd_arbiter.sv
// rtl/sd_arbiter.sv - round-robin arbiter and watchdog in front of the SD block-read engine
// Purpose: share sd_controller between the boot loader (port 0) and the disk-emulation
//   path (port 1); forward the winner's address, pulse the engine request, return the
//   completion to the winner, and reset the engine if a transfer hangs.
// Ports:
//   i_clk_bus, i_res_n            bus clock, asynchronous active-low reset
//   i_req0/1, i_addr0/1           level requests with block addresses
//   o_ack0/1, o_err0/1            one-cycle completion / failure pulses
//   o_buf_sel                     port owning the sector buffer contents
//   o_busy                        high whenever not idle
//   i_sd_ready, i_sd_ack          engine ready level and completion pulse
//   o_sd_res, o_sd_block_addr,
//   o_sd_req                      engine reset, block address, request pulse
import sd_pkg::*;

module sd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = SD_TIMEOUT_DEFAULT,
  parameter int unsigned RES_CYCLES     = SD_RES_CYCLES_DEFAULT
) (
  input  logic        i_clk_bus,
  input  logic        i_res_n,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_addr1,
  output logic        o_ack0,
  output logic        o_ack1,
  output logic        o_err0,
  output logic        o_err1,
  output logic        o_buf_sel,
  output logic        o_busy,
  input  logic        i_sd_ready,
  output logic        o_sd_res,
  output logic [31:0] o_sd_block_addr,
  output logic        o_sd_req,
  input  logic        i_sd_ack
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = $clog2(RES_CYCLES);

  sd_state_t   r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [RW-1:0] r_res_cnt, w_res_cnt_nxt;
  logic        r_sel, w_sel_nxt;
  logic        r_last, w_last_nxt;
  logic        r_fail, w_fail_nxt;
  logic        r_buf_sel, w_buf_sel_nxt;
  logic [31:0] r_sd_addr, w_sd_addr_nxt;
  logic        r_sd_req, w_sd_req_nxt;
  logic        r_sd_res, w_sd_res_nxt;
  logic        r_ack0, w_ack0_nxt;
  logic        r_ack1, w_ack1_nxt;
  logic        r_err0, w_err0_nxt;
  logic        r_err1, w_err1_nxt;
  logic        r_busy, w_busy_nxt;

  logic        w_pick_valid;
  logic        w_pick_sel;

  sd_rr_pick u_pick (
    .i_req0  (i_req0),
    .i_req1  (i_req1),
    .i_last  (r_last),
    .o_valid (w_pick_valid),
    .o_sel   (w_pick_sel)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_res_cnt_nxt = r_res_cnt;
    w_sel_nxt     = r_sel;
    w_last_nxt    = r_last;
    w_fail_nxt    = r_fail;
    w_buf_sel_nxt = r_buf_sel;
    w_sd_addr_nxt = r_sd_addr;
    w_sd_req_nxt  = 1'b0;
    w_sd_res_nxt  = r_sd_res;
    w_ack0_nxt    = 1'b0;
    w_ack1_nxt    = 1'b0;
    w_err0_nxt    = 1'b0;
    w_err1_nxt    = 1'b0;

    case (r_state)
      ST_RECOVER: begin
        w_sd_res_nxt = 1'b1;
        if (r_res_cnt == RW'(RES_CYCLES - 1)) begin
          w_state_nxt   = ST_IDLE;
          w_sd_res_nxt  = 1'b0;
          w_res_cnt_nxt = '0;
        end else begin
          w_res_cnt_nxt = r_res_cnt + RW'(1);
        end
      end
      ST_IDLE: begin
        if (i_sd_ready && w_pick_valid) begin
          w_state_nxt   = ST_ISSUE;
          w_sel_nxt     = w_pick_sel;
          w_buf_sel_nxt = w_pick_sel;
          w_sd_addr_nxt = w_pick_sel ? i_addr1 : i_addr0;
          // Registered so the pulse is high exactly while in ISSUE.
          w_sd_req_nxt  = 1'b1;
        end
      end
      ST_ISSUE: begin
        w_timer_nxt = '0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_timer_nxt = r_timer + TW'(1);
        // Completion beats the watchdog when both land in the same cycle.
        if (i_sd_ack) begin
          w_state_nxt = ST_DONE;
          w_fail_nxt  = 1'b0;
          w_ack0_nxt  = ~r_sel;
          w_ack1_nxt  = r_sel;
        end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt = ST_DONE;
          w_fail_nxt  = 1'b1;
          w_ack0_nxt  = ~r_sel;
          w_ack1_nxt  = r_sel;
          w_err0_nxt  = ~r_sel;
          w_err1_nxt  = r_sel;
        end
      end
      ST_DONE: begin
        w_last_nxt = r_sel;
        if (r_fail) begin
          w_state_nxt   = ST_RECOVER;
          w_sd_res_nxt  = 1'b1;
          w_res_cnt_nxt = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt   = ST_RECOVER;
        w_sd_res_nxt  = 1'b1;
        w_res_cnt_nxt = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge i_clk_bus or negedge i_res_n) begin
    if (!i_res_n) begin
      r_state   <= ST_RECOVER;
      r_timer   <= '0;
      r_res_cnt <= '0;
      r_sel     <= 1'b0;
      r_last    <= 1'b1;
      r_fail    <= 1'b0;
      r_buf_sel <= 1'b0;
      r_sd_addr <= '0;
      r_sd_req  <= 1'b0;
      r_sd_res  <= 1'b1;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_res_cnt <= w_res_cnt_nxt;
      r_sel     <= w_sel_nxt;
      r_last    <= w_last_nxt;
      r_fail    <= w_fail_nxt;
      r_buf_sel <= w_buf_sel_nxt;
      r_sd_addr <= w_sd_addr_nxt;
      r_sd_req  <= w_sd_req_nxt;
      r_sd_res  <= w_sd_res_nxt;
      r_ack0    <= w_ack0_nxt;
      r_ack1    <= w_ack1_nxt;
      r_err0    <= w_err0_nxt;
      r_err1    <= w_err1_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign o_ack0          = r_ack0;
  assign o_ack1          = r_ack1;
  assign o_err0          = r_err0;
  assign o_err1          = r_err1;
  assign o_buf_sel       = r_buf_sel;
  assign o_busy          = r_busy;
  assign o_sd_res        = r_sd_res;
  assign o_sd_block_addr = r_sd_addr;
  assign o_sd_req        = r_sd_req;

endmodule

// File: tb/tb_sd_arbiter.sv
// tb/tb_sd_arbiter.sv - scoreboard bench for sd_arbiter
module tb_sd_arbiter;

  localparam int T  = 100;
  localparam int RC = 4;

  logic        clk = 1'b0;
  logic        res_n;
  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic        sd_ready;
  logic        sd_ack = 1'b0;
  logic        ack0, ack1, err0, err1, buf_sel, busy;
  logic        sd_res, sd_req;
  logic [31:0] sd_block_addr;

  always #5 clk = ~clk;

  sd_arbiter #(.TIMEOUT_CYCLES(T), .RES_CYCLES(RC)) dut (
    .i_clk_bus       (clk),
    .i_res_n         (res_n),
    .i_req0          (req0),
    .i_req1          (req1),
    .i_addr0         (addr0),
    .i_addr1         (addr1),
    .o_ack0          (ack0),
    .o_ack1          (ack1),
    .o_err0          (err0),
    .o_err1          (err1),
    .o_buf_sel       (buf_sel),
    .o_busy          (busy),
    .i_sd_ready      (sd_ready),
    .o_sd_res        (sd_res),
    .o_sd_block_addr (sd_block_addr),
    .o_sd_req        (sd_req),
    .i_sd_ack        (sd_ack)
  );

  typedef struct {
    bit          port;
    bit          err;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int eng_lat   = 0;
  bit pend      = 0;
  int ecnt      = 0;
  int sdack_cyc = 0;
  int req_cyc   = 0;
  int req_count = 0;
  bit prev_req  = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Engine model: acks eng_lat cycles after the sd_req cycle; eng_lat=0 never acks.
  always @(negedge clk) begin
    sd_ack = 1'b0;
    if (!res_n) begin
      pend = 0;
    end else if (sd_req) begin
      pend = 1;
      ecnt = 0;
    end else if (pend && eng_lat > 0) begin
      ecnt++;
      if (ecnt == eng_lat) begin
        sd_ack    = 1'b1;
        pend      = 0;
        sdack_cyc = cyc;
      end
    end
  end

  // Scoreboard: check address/buf_sel at sd_req, pop and check port/err at ack.
  always @(negedge clk) begin : mon
    exp_t e;
    if (res_n) begin
      if (sd_req) begin
        req_count++;
        req_cyc = cyc;
        check("sd_req_single", 32'(prev_req), 32'd0);
        check("sd_req_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check("sd_block_addr", sd_block_addr, exp_q[0].addr);
          check("buf_sel", 32'(buf_sel), 32'(exp_q[0].port));
        end
      end
      prev_req = sd_req;
      if (ack0 || ack1 || err0 || err1) begin
        check("ack_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("ack0", 32'(ack0), 32'(!e.port));
          check("ack1", 32'(ack1), 32'(e.port));
          check("err0", 32'(err0), 32'(e.err && !e.port));
          check("err1", 32'(err1), 32'(e.err && e.port));
        end
      end
    end else begin
      prev_req = 0;
    end
  end

  task automatic wait_ack(input string tag, input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check({tag, "_ack_timeout"}, 32'(ack0 || ack1), 32'd1);
  endtask

  task automatic count_res(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (sd_res) begin
        n++;
        @(negedge clk);
      end else begin
        break;
      end
    end
  endtask

  initial begin
    int at;
    int n;
    int rc;
    bit seen;
    bit m_last;
    bit s;

    res_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; sd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sd_res", 32'(sd_res), 32'd1);
    check("rst_sd_req", 32'(sd_req), 32'd0);
    check("rst_addr", sd_block_addr, 32'd0);
    check("rst_acks", 32'({ack0, ack1, err0, err1}), 32'd0);
    check("rst_buf_sel", 32'(buf_sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);

    // Release reset with the engine not ready and a request already pending.
    req0 = 1'b1; addr0 = 32'h10; res_n = 1'b1;
    count_res(n);
    check("por_res_len", 32'(n), 32'(RC));
    check("idle_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    check("no_grant_not_ready", 32'(req_count), 32'd0);

    // Single transfer on port 0, engine latency 50.
    exp_q.push_back('{port: 1'b0, err: 1'b0, addr: 32'h10});
    eng_lat = 50; sd_ready = 1'b1;
    wait_ack("t1", 200, at);
    req0 = 1'b0;
    check("t1_sdack_to_ack", 32'(at - sdack_cyc), 32'd1);
    check("t1_req_to_ack", 32'(at - req_cyc), 32'd51);
    check("t1_buf_sel", 32'(buf_sel), 32'd0);
    @(negedge clk);

    // Port 1 times out: engine never acks.
    exp_q.push_back('{port: 1'b1, err: 1'b1, addr: 32'h200});
    eng_lat = 0; addr1 = 32'h200; req1 = 1'b1;
    wait_ack("t2", 300, at);
    req1 = 1'b0; sd_ready = 1'b0; req0 = 1'b1; addr0 = 32'hA0;
    rc = req_count;
    check("t2_req_to_err", 32'(at - req_cyc), 32'(T + 1));
    @(negedge clk);
    count_res(n);
    check("timeout_res_len", 32'(n), 32'(RC));
    repeat (10) @(negedge clk);
    check("no_grant_after_recover", 32'(req_count), 32'(rc));
    check("recover_idle_busy", 32'(busy), 32'd0);

    // Both ports held through four transfers; model round-robin from last=1.
    addr1 = 32'hB1; req1 = 1'b1;
    m_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s = ~m_last;
      exp_q.push_back('{port: s, err: 1'b0, addr: s ? 32'hB1 : 32'hA0});
      m_last = s;
    end
    eng_lat = 5; sd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack("rr", 100, at);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // sd_ack in the very cycle the timer reaches TIMEOUT_CYCLES-1.
    exp_q.push_back('{port: 1'b0, err: 1'b0, addr: 32'h3C});
    eng_lat = T; addr0 = 32'h3C; req0 = 1'b1;
    wait_ack("edge", 300, at);
    req0 = 1'b0;
    check("edge_req_to_ack", 32'(at - req_cyc), 32'(T + 1));
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= sd_res;
    end
    check("edge_no_engine_reset", 32'(seen), 32'd0);

    // Asynchronous reset while port 1 is waiting.
    exp_q.push_back('{port: 1'b1, err: 1'b0, addr: 32'h77});
    eng_lat = 0; addr1 = 32'h77; req1 = 1'b1;
    rc = req_count;
    for (int i = 0; i < 20 && req_count == rc; i++) @(negedge clk);
    check("rst_req_issued", 32'(req_count), 32'(rc + 1));
    repeat (10) @(negedge clk);
    #2;
    res_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_sd_res", 32'(sd_res), 32'd1);
    check("arst_sd_req", 32'(sd_req), 32'd0);
    check("arst_addr", sd_block_addr, 32'd0);
    check("arst_buf_sel", 32'(buf_sel), 32'd0);
    check("arst_busy", 32'(busy), 32'd1);
    check("arst_acks", 32'({ack0, ack1, err0, err1}), 32'd0);
    req1 = 1'b0;
    @(negedge clk);
    res_n = 1'b1;
    rc = req_count;
    count_res(n);
    check("arst_res_len", 32'(n), 32'(RC));
    repeat (5) @(negedge clk);
    check("arst_no_new_req", 32'(req_count), 32'(rc));
    check("final_idle_busy", 32'(busy), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_arbiter.md
# sd_arbiter

Shares the single SD block-read engine (sd_controller) between two requesters: port 0 (boot loader) and port 1 (disk-emulation path). Grants round-robin, forwards the winner's block address, issues the one-cycle request, and routes completion back to the winner. A watchdog catches a hung transfer, resets the engine, and reports the failure to the affected requester. Sits between the requesters and sd_controller; the sector buffer's write side stays owned by sd_controller, and buf_sel tells the read side whose data it is.

## Interface
- TIMEOUT_CYCLES, 20000000: clk_bus cycles from sd_req to sd_ack before abort (200 ms at 100 MHz); counter width $clog2(TIMEOUT_CYCLES).
- RES_CYCLES, 4: cycles sd_res is held high per engine reset; minimum 2.
- clk_bus  in  1  100 MHz bus clock, single clock domain.
- res_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  level request; hold high with the address stable until ack or err.
- addr0 / addr1  in  32  block address for the request.
- ack0 / ack1  out  1  one-cycle completion pulse.
- err0 / err1  out  1  one-cycle failure pulse, coincident with ack of the same port.
- buf_sel  out  1  port that owns the sector buffer contents; valid from grant until the next grant.
- busy  out  1  high in every state except IDLE.
- sd_ready  in  1  engine initialised (sd_controller ready).
- sd_res  out  1  engine reset, active-high.
- sd_block_addr  out  32  address to engine.
- sd_req  out  1  one-cycle request pulse to engine.
- sd_ack  in  1  one-cycle completion pulse from engine.

## Operation
- States: RECOVER, IDLE, ISSUE, WAIT, DONE.
- Reset values: state RECOVER, sd_res 1, sd_req 0, sd_block_addr 0, ack*/err* 0, buf_sel 0, last 1 (port 0 wins the first tie), timer 0, busy 1.
- RECOVER: hold sd_res=1 for RES_CYCLES cycles, then deassert it and go to IDLE. The cycle counter starts at 0 on entry.
- IDLE: grant only when sd_ready=1 and at least one of req0/req1 is high.
  - One request: that port wins.
  - Both requests: the port other than last wins.
  - On grant: latch sel, set buf_sel<=sel, sd_block_addr<=addr[sel]; go to ISSUE.
- ISSUE: sd_req=1 for exactly this cycle; timer<=0; go to WAIT.
- WAIT:
  - Increment timer each cycle.
  - sd_ack=1: go to DONE with fail=0.
  - Else if timer==TIMEOUT_CYCLES-1: go to DONE with fail=1.
  - sd_ack takes priority when both occur in the same cycle.
- DONE (one cycle):
  - ack[sel]=1; err[sel]=fail; last<=sel.
  - Next state: IDLE if fail=0, RECOVER if fail=1.
- After RECOVER, the arbiter stays in IDLE until the engine re-asserts sd_ready (its power-up sequence, ≥1.5 ms).
- Requester changes while granted: req or addr changing after grant is ignored; the latched sel and address stand.
- Requester duty: drop req the cycle after ack. IDLE is entered one edge after DONE, so a held req re-arbitrates as a new request.
- An sd_ack outside WAIT is ignored.
- Asynchronous reset mid-transfer returns the block to its reset values immediately. The in-flight requester gets no ack; it must re-request.

## Timing
- Grant to sd_req: 1 cycle (IDLE edge → ISSUE).
- sd_ack to ack*: 1 cycle (ack registered in DONE).
- Minimum request-to-request spacing through the arbiter: IDLE→ISSUE→WAIT→DONE→IDLE, i.e. 3 cycles plus engine latency.
- Timeout: err fires exactly TIMEOUT_CYCLES+1 cycles after the sd_req cycle. sd_res rises the following cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package sd_pkg:
  - state encoding constants (RECOVER=0, IDLE=1, ISSUE=2, WAIT=3, DONE=4, 3-bit);
  - SD_TIMEOUT_DEFAULT.
- One sub-module, sd_rr_pick: combinational 2-way round-robin (inputs req0, req1, last; outputs valid, sel). Reusable if ports are added later.

## Test plan
- Reset release with sd_ready=0 → sd_res high for 4 cycles then low; no grant while sd_ready=0, even with req0=1.
- req0=1, addr0=0x00000010, engine model acks 50 cycles after sd_req → sd_req single pulse, sd_block_addr=0x10, ack0 pulses 1 cycle after sd_ack, err0=0, buf_sel=0.
- req0 and req1 asserted together and held through 4 transfers → grant order 0,1,0,1; each ack lands on the matching port only.
- TIMEOUT_CYCLES=100, engine never acks → ack1 and err1 pulse together 101 cycles after sd_req; sd_res high 4 cycles; no new grant until sd_ready re-asserts.
- sd_ack arrives in the same cycle the timer hits TIMEOUT_CYCLES-1 → ack with err=0; no engine reset.
- res_n pulsed low during WAIT → outputs at reset values asynchronously; no ack for the in-flight port; RECOVER sequence reruns.
